coin_hit_judge: RTL and testbench
=================================

Name: coin_hit_judge

Overview:
- Per-lane hit judge sitting directly downstream of the coin sprite stages (left/centre/right).
- Consumes each coin's active and in-position status plus the player lane buttons, declares hit/miss per coin, and tells the coin spawner to retire the coin.
- Maintains score, combo, lives and game-over for the HUD and the game controller.

Parameters:
- NUM_LANES, 3, number of coin lanes judged in parallel.
- HIT_POINTS, 10, base points per hit.
- COMBO_BONUS_AT, 8, combo count at or above which a hit scores 2*HIT_POINTS.
- WINDOW_FRAMES, 6, max frames a coin may sit in position before an automatic miss.
- LIVES_INIT, 3, lives loaded at reset.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_v_sync  input  1  frame sync, asynchronous to the judge; 2-flop synchronised, rising edge = frame tick.
- i_active  input  NUM_LANES  per-lane coin active (same signal that drives each coin's active input).
- i_in_position  input  NUM_LANES  per-lane coin in-position flag from the coin stage.
- i_btn  input  NUM_LANES  raw lane buttons, 2-flop synchronised, rising edge = press.
- o_clear  output  NUM_LANES  one-cycle pulse: spawner must drop i_active for that lane.
- o_hit_pulse  output  1  one-cycle pulse when one or more lanes score a hit.
- o_miss_pulse  output  1  one-cycle pulse when one or more lanes register a miss.
- o_score  output  16  running score, saturating.
- o_combo  output  8  consecutive hits, saturating at 255.
- o_lives  output  2  remaining lives.
- o_game_over  output  1  sticky, set when lives reach 0.

Behaviour:
- Reset, synchronous, any time: all lanes go to IDLE. o_score=0, o_combo=0, o_lives=LIVES_INIT, o_game_over=0. All pulses=0, sync flops=0, frame counters=0. Reset mid-window discards the pending judgement.
- Input sync: btn/v_sync edges are visible 3 cycles after the pin edge (2 sync flops + edge register). Judgement registers 1 cycle later. All outputs are registered.
- Per-lane FSM:
  - IDLE: enter TRAVEL when i_active=1.
  - TRAVEL: enter WINDOW when i_in_position=1, clearing the frame counter. Enter IDLE if i_active drops. A press here is a ghost press: o_combo<=0, no life loss.
  - WINDOW:
    - Press: hit. o_clear pulse, go to RESOLVED.
    - i_in_position falls with no press: miss.
    - i_active drops with no press: miss.
    - Frame counter reaches WINDOW_FRAMES: miss.
    - Every miss pulses o_clear and goes to RESOLVED.
  - RESOLVED: wait for i_active=0, then IDLE. Presses are ignored. o_clear is not repeated.
- Press and in_position fall in the same cycle: counts as a hit. Press and timeout in the same cycle: counts as a hit.
- Scoring, per cycle, aggregated over lanes:
  - h = number of hits. Each hit adds HIT_POINTS, or 2*HIT_POINTS if the pre-update o_combo >= COMBO_BONUS_AT.
  - Score sum is computed 18-bit and saturates at 16'hFFFF.
  - o_combo += h, saturating at 255.
- Misses, per cycle:
  - m = number of misses. o_lives -= m, floored at 0.
  - If m>0 or any ghost press, o_combo<=0. This overrides hits in the same cycle, but hit points are still added.
- Game over:
  - When o_lives reaches 0, o_game_over<=1 (sticky until reset).
  - Next cycle, every lane in TRAVEL/WINDOW gets an o_clear pulse and goes to RESOLVED.
  - While game over, no further score, combo or lives changes and no hit/miss pulses.
- o_hit_pulse/o_miss_pulse fire in the same cycle as the corresponding o_clear.

Test Plan:
- Reset: assert i_rst mid-WINDOW on lane 0 -> next cycle o_score=0, o_combo=0, o_lives=3, o_game_over=0, no o_clear pulse.
- Hit: lane 1 active, in_position=1, press btn[1] -> exactly 4 cycles after the pin edge o_clear=3'b010 for 1 cycle, o_hit_pulse=1, o_score=10, o_combo=1. Lane returns to IDLE after i_active drops.
- Combo bonus: 8 consecutive hits (score 80, combo 8), then a 9th hit -> o_score=100, o_combo=9. Then an early press on a TRAVEL lane -> o_combo=0, o_lives unchanged.
- Timeout miss: lane 2 in_position held with no press for 6 frame ticks -> o_clear[2] pulse, o_miss_pulse=1, o_lives 3->2, o_combo=0.
- Simultaneous: lanes 0 and 2 hit plus lane 1 miss in the same cycle with combo=3 -> o_score +=20, o_combo=0, o_lives -=1, o_hit_pulse=1 and o_miss_pulse=1 together.
- Game over and saturation:
  - Force 3 misses -> o_lives=0, o_game_over=1. Next cycle o_clear fires for all lanes in TRAVEL/WINDOW. Subsequent presses leave score and combo unchanged.
  - Separately, preload score near 16'hFFFF -> a hit clamps it at 16'hFFFF.

Source files
------------

// File: rtl/coin_hit_judge.sv
// coin_hit_judge: per-lane hit/miss judge for the coin lanes.
// Synchronises the frame sync and lane buttons, runs one small FSM per lane,
// and keeps score, combo, lives and game-over for the HUD and game controller.
module coin_hit_judge #(
  parameter int NUM_LANES      = 3,
  parameter int HIT_POINTS     = 10,
  parameter int COMBO_BONUS_AT = 8,
  parameter int WINDOW_FRAMES  = 6,
  parameter int LIVES_INIT     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_v_sync,
  input  logic [NUM_LANES-1:0] i_active,
  input  logic [NUM_LANES-1:0] i_in_position,
  input  logic [NUM_LANES-1:0] i_btn,
  output logic [NUM_LANES-1:0] o_clear,
  output logic                 o_hit_pulse,
  output logic                 o_miss_pulse,
  output logic [15:0]          o_score,
  output logic [7:0]           o_combo,
  output logic [1:0]           o_lives,
  output logic                 o_game_over
);

  localparam int CNT_W = $clog2(WINDOW_FRAMES + 1);
  localparam int LCW   = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAVEL,
    ST_WINDOW,
    ST_RESOLVED
  } lane_state_e;

  // Synchroniser chains and registered edge strobes
  logic [NUM_LANES-1:0] btn_s1_q, btn_s2_q, btn_s3_q, press_q;
  logic                 vs_s1_q, vs_s2_q, vs_s3_q, tick_q;

  // Per-lane state
  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [CNT_W-1:0]     frame_q [NUM_LANES];
  logic [CNT_W-1:0]     frame_d [NUM_LANES];

  // Per-cycle judgement results
  logic [NUM_LANES-1:0] hit, miss, ghost, clear_d;
  logic [LCW-1:0]       hit_cnt, miss_cnt;

  // HUD state
  logic [15:0]          pts;
  logic [17:0]          score_sum;
  logic [8:0]           combo_sum;
  logic [15:0]          score_q, score_d;
  logic [7:0]           combo_q, combo_d;
  logic [1:0]           lives_q, lives_d;
  logic                 game_over_q, game_over_d;
  logic [NUM_LANES-1:0] clear_q;
  logic                 hit_pulse_q, miss_pulse_q;

  // Two-flop synchronisers plus an edge register for buttons and frame sync
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      btn_s3_q <= '0;
      press_q  <= '0;
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_s3_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, so the chain shifts exactly one flop per clock.
      btn_s1_q <= i_btn;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
      press_q  <= btn_s2_q & ~btn_s3_q;
      vs_s1_q  <= i_v_sync;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      tick_q   <= vs_s2_q & ~vs_s3_q;
    end
  end

  // Lane state and frame counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: these arrays are a handful of flops per lane, not a RAM, so
      // they are reset like any other register.
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= ST_IDLE;
        frame_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= state_d[l];
        frame_q[l] <= frame_d[l];
      end
    end
  end

  // Per-lane next state: hit/miss/ghost decisions and clear requests
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    hit     = '0;
    miss    = '0;
    ghost   = '0;
    clear_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      state_d[l] = state_q[l];
      frame_d[l] = frame_q[l];
      unique case (state_q[l])
        ST_IDLE: begin
          if (i_active[l]) state_d[l] = ST_TRAVEL;
        end
        ST_TRAVEL: begin
          if (game_over_q) begin
            clear_d[l] = 1'b1;
            state_d[l] = ST_RESOLVED;
          end else begin
            ghost[l] = press_q[l];
            if (!i_active[l]) begin
              state_d[l] = ST_IDLE;
            end else if (i_in_position[l]) begin
              state_d[l] = ST_WINDOW;
              frame_d[l] = '0;
            end
          end
        end
        ST_WINDOW: begin
          if (game_over_q) begin
            clear_d[l] = 1'b1;
            state_d[l] = ST_RESOLVED;
          end else if (press_q[l]) begin
            // A press wins over a same-cycle position fall or timeout
            hit[l]     = 1'b1;
            clear_d[l] = 1'b1;
            state_d[l] = ST_RESOLVED;
          end else if (!i_in_position[l] || !i_active[l] ||
                       (tick_q && frame_q[l] == CNT_W'(WINDOW_FRAMES - 1))) begin
            miss[l]    = 1'b1;
            clear_d[l] = 1'b1;
            state_d[l] = ST_RESOLVED;
          end else if (tick_q) begin
            frame_d[l] = frame_q[l] + CNT_W'(1);
          end
        end
        ST_RESOLVED: begin
          if (!i_active[l]) state_d[l] = ST_IDLE;
        end
        default: state_d[l] = ST_IDLE;
      endcase
    end
  end

  // Aggregate lanes into score, combo, lives and game-over updates
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit_cnt  = hit_cnt + LCW'(hit[l]);
      miss_cnt = miss_cnt + LCW'(miss[l]);
    end

    pts       = (combo_q >= 8'(COMBO_BONUS_AT)) ? 16'(2 * HIT_POINTS) : 16'(HIT_POINTS);
    score_sum = 18'(score_q) + 18'(hit_cnt) * 18'(pts);
    score_d   = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];

    combo_sum = 9'(combo_q) + 9'(hit_cnt);
    if ((|miss) || (|ghost)) combo_d = '0;
    else if (combo_sum > 9'd255) combo_d = 8'd255;
    else combo_d = combo_sum[7:0];

    if (32'(miss_cnt) >= 32'(lives_q)) lives_d = '0;
    else lives_d = lives_q - 2'(miss_cnt);

    game_over_d = game_over_q | (lives_d == 2'd0);
  end

  // Registered HUD state and output pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      score_q      <= '0;
      combo_q      <= '0;
      lives_q      <= 2'(LIVES_INIT);
      game_over_q  <= 1'b0;
      clear_q      <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      score_q      <= score_d;
      combo_q      <= combo_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
      clear_q      <= clear_d;
      hit_pulse_q  <= |hit;
      miss_pulse_q <= |miss;
    end
  end

  assign o_clear      = clear_q;
  assign o_hit_pulse  = hit_pulse_q;
  assign o_miss_pulse = miss_pulse_q;
  assign o_score      = score_q;
  assign o_combo      = combo_q;
  assign o_lives      = lives_q;
  assign o_game_over  = game_over_q;

endmodule

// File: tb/tb_coin_hit_judge.sv
// tb_coin_hit_judge: directed stimulus for coin_hit_judge, checked every cycle
// against a lane-lifecycle model plus hand-computed literal expectations.
module tb_coin_hit_judge;

  localparam int WINDOW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_sync;
  logic [2:0]  active, in_pos, btn;
  logic [2:0]  clear;
  logic        hit_p, miss_p;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [1:0]  lives;
  logic        go;

  always #5 clk = ~clk;

  coin_hit_judge dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_v_sync      (v_sync),
    .i_active      (active),
    .i_in_position (in_pos),
    .i_btn         (btn),
    .o_clear       (clear),
    .o_hit_pulse   (hit_p),
    .o_miss_pulse  (miss_p),
    .o_score       (score),
    .o_combo       (combo),
    .o_lives       (lives),
    .o_game_over   (go)
  );

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each lane's coin is tracked as: not present / present awaiting window /
  // in window / judged. Button and frame edges are taken from a history of
  // pin samples: an edge on the pin is acted on three clocks after capture.
  bit         m_valid = 1'b0;
  bit         m_present [3];
  bit         m_in_win  [3];
  bit         m_judged  [3];
  int         m_frames  [3];
  logic [2:0] m_bh [5];
  logic       m_vh [5];
  int         m_score, m_combo, m_lives;
  bit         m_go;
  logic [2:0] exp_clear;
  bit         exp_hit, exp_miss;
  logic [2:0] m_press;
  bit         m_tick, m_ghost;
  int         m_hits, m_misses;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin m_bh[k] = '0; m_vh[k] = 1'b0; end
      for (int l = 0; l < 3; l++) begin
        m_present[l] = 0; m_in_win[l] = 0; m_judged[l] = 0; m_frames[l] = 0;
      end
      m_score = 0; m_combo = 0; m_lives = 3; m_go = 0;
      exp_clear = '0; exp_hit = 0; exp_miss = 0;
    end else begin
      for (int k = 4; k > 0; k--) begin m_bh[k] = m_bh[k-1]; m_vh[k] = m_vh[k-1]; end
      m_bh[0] = btn;
      m_vh[0] = v_sync;
      m_press = m_bh[3] & ~m_bh[4];
      m_tick  = m_vh[3] & ~m_vh[4];
      m_hits = 0; m_misses = 0; m_ghost = 0; exp_clear = '0;
      for (int l = 0; l < 3; l++) begin
        if (!m_present[l]) begin
          if (active[l]) m_present[l] = 1;
        end else if (m_judged[l]) begin
          if (!active[l]) begin m_present[l] = 0; m_judged[l] = 0; end
        end else if (m_go) begin
          exp_clear[l] = 1; m_judged[l] = 1; m_in_win[l] = 0;
        end else if (!m_in_win[l]) begin
          if (m_press[l]) m_ghost = 1;
          if (!active[l]) m_present[l] = 0;
          else if (in_pos[l]) begin m_in_win[l] = 1; m_frames[l] = 0; end
        end else if (m_press[l]) begin
          m_hits++; exp_clear[l] = 1; m_judged[l] = 1; m_in_win[l] = 0;
        end else begin
          if (m_tick) m_frames[l]++;
          if (!in_pos[l] || !active[l] || m_frames[l] == WINDOW) begin
            m_misses++; exp_clear[l] = 1; m_judged[l] = 1; m_in_win[l] = 0;
          end
        end
      end
      m_score += m_hits * ((m_combo >= 8) ? 20 : 10);
      if (m_score > 65535) m_score = 65535;
      if (m_misses > 0 || m_ghost) m_combo = 0;
      else m_combo = (m_combo + m_hits > 255) ? 255 : m_combo + m_hits;
      m_lives = (m_lives - m_misses < 0) ? 0 : m_lives - m_misses;
      if (m_lives == 0) m_go = 1;
      exp_hit  = (m_hits > 0);
      exp_miss = (m_misses > 0);
    end
  end

  // Compare DUT against the model on every falling edge once reset was seen
  always @(negedge clk) begin
    if (m_valid) begin
      check("clear",      clear,  exp_clear);
      check("hit_pulse",  hit_p,  exp_hit);
      check("miss_pulse", miss_p, exp_miss);
      check("score",      score,  m_score);
      check("combo",      combo,  m_combo);
      check("lives",      lives,  m_lives);
      check("game_over",  go,     m_go);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spawn_window(input logic [2:0] m);
    active = active | m;
    step(1);
    in_pos = in_pos | m;
    step(1);
  endtask

  // Press lanes in m; returns just after the judging edge
  task automatic press_judge(input logic [2:0] m);
    btn = m;
    step(2);
    btn = '0;
    step(2);
  endtask

  task automatic retire(input logic [2:0] m);
    active = active & ~m;
    in_pos = in_pos & ~m;
    step(1);
  endtask

  task automatic frame_pulse();
    v_sync = 1'b1;
    step(2);
    v_sync = 1'b0;
    step(2);
  endtask

  task automatic miss_by_fall(input logic [2:0] m);
    active = active | m;
    step(1);
    in_pos = in_pos | m;
    step(1);
    in_pos = in_pos & ~m;
    step(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; v_sync = 1'b0; active = '0; in_pos = '0; btn = '0;
    step(2);
    rst = 1'b0;
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_lives", lives, 3);
    check("rst_go",    go,    0);
    check("rst_clear", clear, 0);

    // Single hit on lane 1
    spawn_window(3'b010);
    press_judge(3'b010);
    check("hit_clear", clear, 3'b010);
    check("hit_pulse1", hit_p, 1);
    check("hit_score", score, 10);
    check("hit_combo", combo, 1);
    retire(3'b010);
    check("hit_clear_once", clear, 3'b000);

    // Seven more hits reach combo 8, the ninth earns the bonus
    for (int i = 0; i < 7; i++) begin
      spawn_window(3'b010);
      press_judge(3'b010);
      retire(3'b010);
    end
    check("combo8_score", score, 80);
    check("combo8_combo", combo, 8);
    spawn_window(3'b010);
    press_judge(3'b010);
    check("bonus_score", score, 100);
    check("bonus_combo", combo, 9);
    retire(3'b010);

    // Ghost press on a travelling lane 0
    active = 3'b001;
    step(1);
    press_judge(3'b001);
    check("ghost_combo", combo, 0);
    check("ghost_lives", lives, 3);
    check("ghost_clear", clear, 0);
    retire(3'b001);

    // Timeout miss on lane 2 after six frame ticks
    spawn_window(3'b100);
    for (int i = 0; i < 5; i++) frame_pulse();
    check("pre_timeout_lives", lives, 3);
    frame_pulse();
    check("timeout_clear", clear, 3'b100);
    check("timeout_miss",  miss_p, 1);
    check("timeout_lives", lives, 2);
    check("timeout_combo", combo, 0);
    retire(3'b100);

    // Build combo 3, then two hits and one miss in the same cycle
    for (int i = 0; i < 3; i++) begin
      spawn_window(3'b001);
      press_judge(3'b001);
      retire(3'b001);
    end
    check("pre_sim_score", score, 130);
    check("pre_sim_combo", combo, 3);
    spawn_window(3'b111);
    btn = 3'b101;
    step(2);
    btn = '0;
    step(1);
    in_pos = 3'b101;
    step(1);
    check("sim_clear", clear, 3'b111);
    check("sim_hit",   hit_p, 1);
    check("sim_miss",  miss_p, 1);
    check("sim_score", score, 150);
    check("sim_combo", combo, 0);
    check("sim_lives", lives, 1);
    retire(3'b111);

    // Reset while lane 0 has a press in flight
    spawn_window(3'b001);
    btn = 3'b001;
    step(1);
    rst = 1'b1; btn = '0; active = '0; in_pos = '0;
    step(1);
    check("midrst_score", score, 0);
    check("midrst_lives", lives, 3);
    check("midrst_clear", clear, 0);
    step(1);
    rst = 1'b0;
    step(4);
    check("postrst_clear", clear, 0);
    check("postrst_score", score, 0);

    // Game over: one hit, then three misses with lanes 1/2 still live
    spawn_window(3'b001);
    press_judge(3'b001);
    retire(3'b001);
    miss_by_fall(3'b001); retire(3'b001);
    miss_by_fall(3'b001); retire(3'b001);
    check("go_pre_lives", lives, 1);
    active = 3'b110;
    step(1);
    in_pos = 3'b100;
    step(1);
    miss_by_fall(3'b001);
    check("go_lives", lives, 0);
    check("go_flag",  go, 1);
    check("go_clear_miss", clear, 3'b001);
    step(1);
    check("go_clear_all", clear, 3'b110);
    check("go_no_miss", miss_p, 0);
    retire(3'b111);
    spawn_window(3'b010);
    press_judge(3'b111);
    check("go_hold_score", score, 10);
    check("go_hold_combo", combo, 0);
    check("go_hold_hit",   hit_p, 0);
    retire(3'b111);

    // Score saturation with all three lanes hitting each round
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int r = 0; r < 1100; r++) begin
      active = 3'b111;
      step(1);
      in_pos = 3'b111;
      step(1);
      btn = 3'b111;
      step(1);
      btn = '0;
      step(3);
      if (r == 1092) check("sat_near_score", score, 65490);
      if (r == 1093) check("sat_clamp_score", score, 16'hFFFF);
      active = '0; in_pos = '0;
      step(1);
    end
    check("sat_score", score, 16'hFFFF);
    check("sat_combo", combo, 255);
    check("sat_lives", lives, 3);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
